test_code: RTL and testbench
============================

Name: test_code

Overview:
- Serial bit-stream pattern detector: samples one bit per clock on data_in and raises data_out for one cycle whenever the most recent PATTERN_W bits equal PATTERN.
- Leaf block used as a simple serial-protocol marker/sync detector.
- Output is registered.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1010, pattern to detect; MSB is the oldest bit received, LSB is the newest.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = bit history restarts after each match.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- data_in  input  1  serial data bit, sampled on every rising clk edge.
- data_out  output  1  registered match pulse.

Behaviour:
- Reset (reset==0, asynchronous):
  - History register cleared to 0.
  - Fill counter cleared to 0.
  - data_out = 0 immediately, independent of clk.
  - data_in is ignored while reset is low.
- Reset release is sampled synchronously; the first bit is taken at the first rising edge with reset==1.
- Each rising edge with reset==1:
  - hist_next = {hist[PATTERN_W-2:0], data_in}.
  - Fill counter increments, saturating at PATTERN_W.
- Match condition, evaluated on the next-state values: fill_next==PATTERN_W and hist_next==PATTERN.
- data_out <= match condition, so data_out is high for exactly the clock cycle following the edge that sampled the final pattern bit (latency 1 cycle from that bit's sampling edge).
- No match is possible before PATTERN_W bits have been received since reset. This avoids false matches against the zero-filled history, e.g. PATTERN=0000.
- OVERLAP=1: history is kept after a match. For 1010, the stream 1010 10 gives matches at bits 4 and 6.
- OVERLAP=0: on a match, the fill counter resets to 0 (history contents become don't-care). The next match needs PATTERN_W fresh bits, so 101010 gives only one match, at bit 4.
- Back-to-back matches (OVERLAP=1 with periodic patterns such as 1111) hold data_out high on consecutive cycles.
- Reset asserted mid-stream: the partial history is discarded, data_out drops immediately, and detection restarts from an empty history.
- No state machine beyond the history register and fill counter (the counter is clog2(PATTERN_W+1) bits wide).
- Elaboration check: PATTERN_W outside 2..16 is a fatal error; PATTERN is truncated or zero-extended to PATTERN_W bits.

Decomposition:
- Shared package test_code_pkg:
  - DEFAULT_PATTERN_W = 4.
  - DEFAULT_PATTERN = 4'b1010.
  - Function clog2 for the fill-counter width.
- One natural sub-module, bit_history: a PATTERN_W-bit shift register plus saturating fill counter, with a clear input. The top level holds the compare, the OVERLAP clear logic and the data_out register.

Test Plan:
- Reset check: hold reset=0 for 3 cycles while toggling data_in -> data_out stays 0. Assert reset=0 asynchronously between edges while data_out=1 -> data_out goes 0 without a clock edge.
- Basic detect, defaults: release reset, drive 1,0,1,0 on successive edges -> data_out=1 only in the cycle after the 4th bit, 0 otherwise.
- Overlap, defaults: drive 1,0,1,0,1,0,1,0 -> data_out pulses after bits 4, 6 and 8 (three single-cycle pulses, two cycles apart).
- Non-overlap (OVERLAP=0): same 8-bit stream -> pulses after bits 4 and 8 only.
- Fill guard (PATTERN=4'b0000): release reset and drive 0,0,0 -> no pulse. Fourth 0 -> pulse after bit 4. Further 0s with OVERLAP=1 -> data_out held high continuously.
- Mid-stream reset: drive 1,0,1, pulse reset low for one cycle, then drive 0,1,0 -> no pulse. Continue with 1,0 -> pulse only after the final 0, i.e. after the full 1010 seen post-reset.

Source files
------------

// File: rtl/test_code_pkg.sv
// test_code_pkg: shared defaults and width helper for the serial pattern detector
package test_code_pkg;
   localparam int DEFAULT_PATTERN_W = 4;
   localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/test_code_bit_history.sv
// test_code_bit_history: serial shift register plus saturating fill counter with clear
module test_code_bit_history
   import test_code_pkg::*;
#(
   parameter int PATTERN_W = DEFAULT_PATTERN_W,
   parameter int FILL_W = clog2(PATTERN_W + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 data_in,
   output logic [PATTERN_W-1:0] hist_next,
   output logic [FILL_W-1:0]    fill_next
);
   logic [PATTERN_W-1:0] hist;
   logic [FILL_W-1:0]    fill;
   // newest bit enters at the LSB; fill counts received bits up to PATTERN_W
   always_comb begin
      hist_next = {hist[PATTERN_W-2:0], data_in};
      fill_next = (fill == FILL_W'(PATTERN_W)) ? fill : fill + 1'b1;
   end
   // clear restarts the fill count so the next match needs a full fresh window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist <= '0;
         fill <= '0;
      end else begin
         hist <= hist_next;
         fill <= clear ? '0 : fill_next;
      end
   end
endmodule

// File: rtl/test_code.sv
// test_code: serial bit-stream pattern detector with registered match pulse
module test_code
   import test_code_pkg::*;
#(
   parameter int          PATTERN_W = DEFAULT_PATTERN_W,
   parameter logic [15:0] PATTERN   = 16'(DEFAULT_PATTERN),
   parameter bit          OVERLAP   = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic data_in,
   output logic data_out
);
   localparam int FILL_W = clog2(PATTERN_W + 1);
   localparam logic [PATTERN_W-1:0] PAT = PATTERN_W'(PATTERN);
   if (PATTERN_W < 2 || PATTERN_W > 16) begin : g_bad_width
      $fatal(1, "test_code: PATTERN_W must be in 2..16");
   end
   logic [PATTERN_W-1:0] hist_next;
   logic [FILL_W-1:0]    fill_next;
   logic                 match;
   logic                 clear;
   test_code_bit_history #(.PATTERN_W(PATTERN_W), .FILL_W(FILL_W)) u_hist (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .data_in   (data_in),
      .hist_next (hist_next),
      .fill_next (fill_next)
   );
   // match only once a full window has arrived, so zero-filled history never matches
   always_comb begin
      match = (fill_next == FILL_W'(PATTERN_W)) && (hist_next == PAT);
      clear = !OVERLAP && match;
   end
   // one-cycle registered pulse after the edge that sampled the final pattern bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) data_out <= 1'b0;
      else data_out <= match;
   end
endmodule

// File: tb/tb_test_code.sv
// tb_test_code: table-driven check of three detector configurations sharing one stream
module tb_test_code;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic data_in = 1'b0;
   logic out_a, out_b, out_c;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      logic r;
      logic d;
      logic ea;
      logic eb;
      logic ec;
   } vec_t;
   vec_t v[$];

   always #5 clk = ~clk;

   test_code dut_a (.clk(clk), .reset(reset), .data_in(data_in), .data_out(out_a));
   test_code #(.OVERLAP(1'b0)) dut_b (.clk(clk), .reset(reset), .data_in(data_in), .data_out(out_b));
   test_code #(.PATTERN(16'h0000)) dut_c (.clk(clk), .reset(reset), .data_in(data_in), .data_out(out_c));

   task automatic chk(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic d, input logic ea, input logic eb, input logic ec);
      v.push_back('{r: r, d: d, ea: ea, eb: eb, ec: ec});
   endtask

   task automatic step(input logic r, input logic d);
      @(negedge clk);
      reset = r;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held for three cycles while data_in toggles
      add(0, 1, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 1, 0, 0, 0);
      // 10101010: overlap pulses at bits 4,6,8; non-overlap at 4,8
      add(1, 1, 0, 0, 0); add(1, 0, 0, 0, 0); add(1, 1, 0, 0, 0); add(1, 0, 1, 1, 0);
      add(1, 1, 0, 0, 0); add(1, 0, 1, 0, 0); add(1, 1, 0, 0, 0); add(1, 0, 1, 1, 0);
      // fill guard for pattern 0000, then held high while zeros continue
      add(0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 1);
      add(1, 0, 0, 0, 1); add(1, 0, 0, 0, 1);
      // mid-stream reset discards a partial 101
      add(0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0); add(1, 0, 0, 0, 0); add(1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0); add(1, 1, 0, 0, 0); add(1, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0); add(1, 0, 1, 1, 0); add(1, 1, 0, 0, 0);

      #1 reset = 1'b0;
      #1;
      chk("reset_a", out_a, 1'b0);
      chk("reset_b", out_b, 1'b0);
      chk("reset_c", out_c, 1'b0);

      foreach (v[i]) begin
         step(v[i].r, v[i].d);
         chk($sformatf("vec%0d_a", i), out_a, v[i].ea);
         chk($sformatf("vec%0d_b", i), out_b, v[i].eb);
         chk($sformatf("vec%0d_c", i), out_c, v[i].ec);
      end

      // asynchronous reset between edges while dut_c is holding its output high
      step(0, 0);
      for (int i = 0; i < 4; i++) step(1, 0);
      chk("async_pre_c", out_c, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("async_drop_c", out_c, 1'b0);
      step(0, 1);
      chk("async_hold_c", out_c, 1'b0);
      // back-to-back 1111 on default pattern must never match
      for (int i = 0; i < 5; i++) step(1, 1);
      chk("ones_a", out_a, 1'b0);
      chk("ones_c", out_c, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
